// File: rtl/vecmac_accumulator.sv
// vecmac_accumulator: sums a valid-qualified stream of unsigned 16-bit
// products into dot-product results of up to VEC_LEN elements and holds
// each result in a one-entry ready/valid output buffer. The input side
// never stalls, so a result arriving while the buffer is full is dropped
// and the sticky overrun flag is set.
module vecmac_accumulator #(
  parameter int VEC_LEN = 8,
  parameter int ACC_W   = 24,
  parameter int LEN_W   = $clog2(VEC_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [15:0]      product,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [LEN_W-1:0] out_len,
  output logic             overrun
);

  localparam int DATA_W = 16;
  localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(VEC_LEN - 1);

  // Zero-extend a product to accumulator width; sums wrap modulo 2^ACC_W.
  function automatic logic [ACC_W-1:0] extend_product(input logic [DATA_W-1:0] p);
    logic [ACC_W+DATA_W-1:0] wide;
    wide = {{ACC_W{1'b0}}, p};
    return wide[ACC_W-1:0];
  endfunction

  // Wrapping accumulate of two unsigned ACC_W values.
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    return a + b;
  endfunction

  logic [CNT_W-1:0] cnt_p0;
  logic [ACC_W-1:0] acc_p0;

  logic [ACC_W-1:0] term;
  logic [LEN_W-1:0] term_len;
  logic             close;
  logic             drain;

  // Next running sum, element count and close/drain decisions for this cycle.
  always_comb begin
    term     = (cnt_p0 == '0) ? extend_product(product)
                              : acc_add(acc_p0, extend_product(product));
    term_len = LEN_W'(cnt_p0) + LEN_W'(1);
    close    = in_valid & (in_last | (cnt_p0 == CNT_MAX));
    drain    = out_valid & out_ready;
  end

  // ---- stage p0: accumulator and element counter ----
  // Partial sum updates; a close returns to EMPTY so the next element can
  // start a new vector on the following cycle with no dead cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0 <= '0;
      acc_p0 <= '0;
    end else if (clr) begin
      cnt_p0 <= '0;
    end else if (in_valid) begin
      if (close) begin
        cnt_p0 <= '0;
      end else begin
        acc_p0 <= term;
        cnt_p0 <= cnt_p0 + CNT_W'(1);
      end
    end
  end

  // ---- stage p1: one-entry output buffer and overrun flag ----
  // A close loads the buffer when it is empty or draining this cycle,
  // otherwise the new result is lost and overrun latches until clr/rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_len   <= '0;
      overrun   <= 1'b0;
    end else if (clr) begin
      overrun <= 1'b0;
      if (drain) begin
        out_valid <= 1'b0;
      end
    end else if (close) begin
      if (!out_valid || drain) begin
        out_valid <= 1'b1;
        out_sum   <= term;
        out_len   <= term_len;
      end else begin
        overrun <= 1'b1;
      end
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vecmac_accumulator.sv
// Directed testbench for vecmac_accumulator (VEC_LEN=8, ACC_W=24).
module tb_vecmac_accumulator;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic [15:0] product;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_sum;
  logic [3:0]  out_len;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  vecmac_accumulator #(.VEC_LEN(8), .ACC_W(24), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .product(product), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_len(out_len), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one input cycle, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [15:0] p, input logic l);
    in_valid = v;
    product  = p;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    product  = '0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; product = '0; in_last = 1'b0;
    out_ready = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_sum", out_sum, 0);
    chk("reset_len", out_len, 0);
    chk("reset_overrun", overrun, 0);
    rst = 1'b0;
    step(0, 0, 0);

    // Full vector 1..8
    for (int i = 1; i <= 7; i++) step(1, 16'(i), 0);
    chk("full_no_early_valid", out_valid, 0);
    step(1, 8, 0);
    chk("full_valid", out_valid, 1);
    chk("full_sum", out_sum, 36);
    chk("full_len", out_len, 8);
    chk("full_overrun", overrun, 0);
    step(0, 0, 0);
    chk("full_one_cycle", out_valid, 0);

    // Width corner: 8 x 65025, back-to-back then with bubbles
    for (int i = 0; i < 8; i++) step(1, 16'd65025, 0);
    chk("wide_valid", out_valid, 1);
    chk("wide_sum", out_sum, 520200);
    chk("wide_len", out_len, 8);
    step(0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 16'd65025, 0);
      if (i < 7) begin
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
      end
    end
    chk("bubble_valid", out_valid, 1);
    chk("bubble_sum", out_sum, 520200);
    chk("bubble_len", out_len, 8);
    step(0, 0, 0);
    chk("bubble_drained", out_valid, 0);

    // Early close then full vector back-to-back
    step(1, 10, 0);
    step(1, 20, 0);
    step(1, 30, 1);
    chk("early_valid", out_valid, 1);
    chk("early_sum", out_sum, 60);
    chk("early_len", out_len, 3);
    step(1, 1, 0);
    chk("early_drained", out_valid, 0);
    for (int i = 2; i <= 8; i++) step(1, 16'(i), 0);
    chk("after_early_sum", out_sum, 36);
    chk("after_early_len", out_len, 8);
    step(0, 0, 0);

    // Backpressure / overrun
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) step(1, 1, 0);
    chk("bp_first_valid", out_valid, 1);
    chk("bp_first_sum", out_sum, 8);
    chk("bp_no_overrun_yet", overrun, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 0);
    chk("bp_held_valid", out_valid, 1);
    chk("bp_held_sum", out_sum, 8);
    chk("bp_overrun", overrun, 1);
    out_ready = 1'b1;
    step(0, 0, 0);
    chk("bp_drained", out_valid, 0);
    chk("bp_overrun_sticky", overrun, 1);
    clr = 1'b1;
    step(0, 0, 0);
    clr = 1'b0;
    chk("clr_overrun", overrun, 0);

    // Simultaneous drain and close
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) step(1, 16'(i), 0);
    for (int i = 0; i < 7; i++) step(1, 2, 0);
    chk("sim_held_sum", out_sum, 36);
    out_ready = 1'b1;
    step(1, 2, 0);
    chk("sim_valid", out_valid, 1);
    chk("sim_sum", out_sum, 16);
    chk("sim_len", out_len, 8);
    chk("sim_overrun", overrun, 0);
    step(0, 0, 0);
    chk("sim_drained", out_valid, 0);

    // Reset mid-vector
    for (int i = 0; i < 4; i++) step(1, 100, 0);
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step(1, 2, 0);
    chk("rst_no_early_valid", out_valid, 0);
    step(1, 2, 0);
    chk("rst_sum", out_sum, 16);
    chk("rst_len", out_len, 8);
    step(0, 0, 0);

    // Clear mid-vector with a product in the same cycle
    for (int i = 0; i < 4; i++) step(1, 100, 0);
    clr = 1'b1;
    step(1, 100, 0);
    clr = 1'b0;
    chk("clr_no_valid", out_valid, 0);
    for (int i = 0; i < 7; i++) step(1, 2, 0);
    chk("clr_no_early_valid", out_valid, 0);
    step(1, 2, 0);
    chk("clr_valid", out_valid, 1);
    chk("clr_sum", out_sum, 16);
    chk("clr_len", out_len, 8);
    step(0, 0, 0);

    // in_last on the first element
    step(1, 777, 1);
    chk("single_sum", out_sum, 777);
    chk("single_len", out_len, 1);
    step(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vecmac_accumulator.md
# vecmac_accumulator

Downstream stage of the unsigned 8×8 Wallace multiplier in the INT8 vector-MAC datapath. Consumes the multiplier's valid-qualified 16-bit product stream, sums VEC_LEN consecutive products (or fewer, if the vector is closed early) into one dot-product result, and presents that result on a one-entry ready/valid output buffer. The multiplier has no backpressure, so input is never stalled; a result that cannot be buffered is dropped and flagged.

## Interface
- VEC_LEN, 8: elements per full vector, ≥2.
- ACC_W, 24: accumulator/result width; must be ≥ 16+clog2(VEC_LEN) for exact results, otherwise sums wrap modulo 2^ACC_W.
- LEN_W, clog2(VEC_LEN+1): width of out_len.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear: discards any partial vector and clears overrun.
- in_valid  in  1  product valid, driven from the multiplier's out_valid.
- product  in  16  unsigned product.
- in_last  in  1  closes the current vector with this element; qualified by in_valid.
- out_valid  out  1  result buffer holds a result.
- out_ready  in  1  consumer accepts the result when high with out_valid.
- out_sum  out  ACC_W  dot-product result.
- out_len  out  LEN_W  number of elements summed into out_sum (1..VEC_LEN).
- overrun  out  1  sticky flag: a completed result was dropped.

## Operation
- State is cnt (0..VEC_LEN-1) and acc (ACC_W bits). cnt==0 is EMPTY; cnt>0 is ACCUM.
- Element accepted when in_valid=1. term = (cnt==0) ? product : acc+product, zero-extended to ACC_W.
- Close condition: in_valid & (in_last | cnt==VEC_LEN-1).
  - No close: acc<=term, cnt<=cnt+1.
  - Close: cnt<=0, and the result {term, cnt+1} is offered to the buffer. acc is don't-care.
- in_valid=0 cycles are bubbles. cnt and acc hold, with no timeout.
- Buffer, evaluated each cycle:
  - drain = out_valid & out_ready.
  - On close, if !out_valid | drain: load out_sum/out_len and set out_valid=1.
  - On close otherwise (buffer full, no drain): the new result is dropped, overrun<=1, and the buffered result is unchanged.
  - On drain without close: out_valid<=0.
  - Drain and close in the same cycle: out_valid stays 1 with the new result.
- clr=1: cnt<=0 and overrun<=0. The in_valid element in the same cycle is discarded. The output buffer is unaffected and can still drain.
- Priority: rst > clr > in_valid.
- out_sum/out_len are stable while out_valid=1 and no drain.
- in_last with cnt==VEC_LEN-1 is a single close, not two.
- in_last on the first element gives out_len=1, out_sum=product.

## Timing
- Reset values: out_valid=0, out_sum=0, out_len=0, overrun=0. Internally cnt=0, acc=0.
- rst mid-vector discards the partial vector and any buffered result.
- Latency: out_valid rises on the clock edge after the closing element is sampled, i.e. 1 cycle after the multiplier presents the last product.
- Throughput: one product per cycle sustained, with back-to-back vectors and no dead cycle between the close and the next vector's first element.
- Under sustained out_ready=1, no overrun occurs for any VEC_LEN≥1 stream.
- All outputs are registered. There is no combinational path from in_* or out_ready to any output.

## Test plan
- Full vector: VEC_LEN=8, products 1..8 on consecutive cycles, out_ready=1 → one cycle after the 8th product: out_valid=1 for exactly 1 cycle, out_sum=36, out_len=8, overrun=0.
- Width corner: eight products of 65025 (255×255) → out_sum=520200 (0x07F008), out_len=8. A following vector with bubbles between elements (3 idle cycles after each) gives the same result.
- Early close: products 10, 20, 30 with in_last on 30, then products 1..8 → first result out_sum=60, out_len=3; second result out_sum=36, out_len=8.
- Backpressure/overrun: out_ready=0, two full vectors of all-1 products → out_valid=1, out_sum=8 held, overrun=1 after the second close. out_ready=1 drains the 8 and out_valid falls. A clr pulse then makes overrun=0.
- Simultaneous drain and close: buffer holds 36 with out_ready=0; raise out_ready on the exact cycle the next vector's (all-2) closing product is sampled → next cycle out_valid=1, out_sum=16, overrun=0.
- Reset/clear mid-operation: 4 products of 100, then rst for one cycle, then eight products of 2 → out_sum=16, out_len=8. Repeating with clr plus in_valid in the same cycle instead of rst also gives out_sum=16 (the product presented with clr is discarded).
